// File: rtl/prbs16_checker.sv
// Receive-side checker for the 16-bit XNOR LFSR stream: self-synchronises,
// declares lock, then counts bit errors with a flywheel predictor.
`timescale 1ns/1ps
module prbs16_checker #(
    parameter int LOCK_COUNT = 32,
    parameter int LOSS_COUNT = 8,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic                 stuck
);

    // state  | meaning
    // HUNT   | filling the shift register with 16 raw stream bits
    // SYNC   | counting consecutive correct predictions towards lock
    // LOCKED | flywheel prediction; mismatches are counted as bit errors

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(LOSS_COUNT + 1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t                state_q, state_d;
    logic [15:0]           sr_q, sr_d;
    logic [4:0]            fill_q, fill_d;
    logic [GW-1:0]         good_q, good_d;
    logic [MW-1:0]         miss_q, miss_d;
    logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;
    logic                  err_pulse_q, err_pulse_d;
    logic                  stuck_q, stuck_d;
    logic                  exp_bit;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            miss_q      <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            stuck_q     <= stuck_d;
        end
    end

    always_comb begin
        exp_bit     = ~(sr_q[15] ^ sr_q[14] ^ sr_q[12] ^ sr_q[3]);
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        good_d      = good_q;
        miss_d      = miss_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;

        if (bit_valid) begin
            case (state_q)
                HUNT: begin
                    sr_d   = {sr_q[14:0], bit_in};
                    fill_d = fill_q + 5'd1;
                    if (fill_q == 5'd15) begin
                        state_d = SYNC;
                        good_d  = '0;
                    end
                end
                SYNC: begin
                    sr_d = {sr_q[14:0], bit_in};
                    // The all-ones lock-up pattern predicts itself, so it must never count as good.
                    if ((bit_in == exp_bit) && (sr_q != 16'hFFFF)) begin
                        good_d = good_q + GW'(1);
                        if (good_d == GW'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    // Shift the prediction so a corrupted bit cannot poison later predictions.
                    sr_d = {sr_q[14:0], exp_bit};
                    if (bit_in != exp_bit) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1)
                            err_count_d = err_count_q + ERR_WIDTH'(1);
                        miss_d = miss_q + MW'(1);
                        if (miss_d == MW'(LOSS_COUNT)) begin
                            state_d = HUNT;
                            fill_d  = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (clr_err)
            err_count_d = '0;

        stuck_d = (sr_d == 16'hFFFF);
    end

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign stuck     = stuck_q;

endmodule
